// File: rtl/rv32i_pkg.sv
// Shared encodings and pipeline register layouts for the five-stage RV32I core.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       mux_reg;
    logic       mux_ula;
    logic [1:0] ula_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mux_reg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wdata;
  } exmem_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mux_reg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mdata;
  } memwb_t;

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 register file: two read ports with write-through, one write port, x0 hardwired to zero.
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [0:31];

  // No reset: preloaded contents must survive a core reset.
  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) regs[wa] <= wd;
  end

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/rv32i_pipeline.sv
// Five-stage in-order RV32I core with ID-stage branches, EX forwarding and load-use stalls.
module rv32i_pipeline
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] pc_out,
  output logic [31:0] out_instruction
);

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];

  logic [31:0] pc, ifid_pc, ifid_instr;
  idex_t       idex, idex_next;
  exmem_t      exmem, exmem_next;
  memwb_t      memwb, memwb_next;

  assign pc_out          = pc;
  assign out_instruction = imem[pc[9:2]];

  // ---------------- ID ----------------
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_id;
  ctrl_t       ctrl_id;
  logic        use_rs1, use_rs2, is_branch;

  assign opcode = ifid_instr[6:0];
  assign rd     = ifid_instr[11:7];
  assign funct3 = ifid_instr[14:12];
  assign rs1    = ifid_instr[19:15];
  assign rs2    = ifid_instr[24:20];
  assign imm_i  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s  = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b  = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                   ifid_instr[30:25], ifid_instr[11:8], 1'b0};

  always_comb begin
    ctrl_id   = '0;
    imm_id    = imm_i;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl_id.reg_wr = 1'b1; ctrl_id.ula_op = ULA_FUNCT;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_id.reg_wr = 1'b1; ctrl_id.mux_ula = 1'b1; ctrl_id.ula_op = ULA_FUNCT;
        use_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_id.reg_wr = 1'b1; ctrl_id.mem_rd = 1'b1; ctrl_id.mux_reg = 1'b1;
        ctrl_id.mux_ula = 1'b1; ctrl_id.ula_op = ULA_ADD;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl_id.mem_wr = 1'b1; ctrl_id.mux_ula = 1'b1; ctrl_id.ula_op = ULA_ADD;
        imm_id = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_id.ula_op = ULA_SUB;
        imm_id = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; is_branch = 1'b1;
      end
      default: ;
    endcase
  end

  logic        rf_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, rf_rd1, rf_rd2;

  rv32i_regfile u_rf (
    .clk(clk), .we(rf_we), .wa(wb_rd), .wd(wb_data),
    .ra1(rs1), .ra2(rs2), .rd1(rf_rd1), .rd2(rf_rd2)
  );

  // Branch operands: EX/MEM ALU results bypass here; MEM/WB arrives via write-through.
  logic [31:0] br_a, br_b;
  logic        exmem_alu_fwd;
  assign exmem_alu_fwd = exmem.reg_wr && !exmem.mem_rd && exmem.rd != 5'd0;
  assign br_a = (exmem_alu_fwd && exmem.rd == rs1) ? exmem.alu : rf_rd1;
  assign br_b = (exmem_alu_fwd && exmem.rd == rs2) ? exmem.alu : rf_rd2;

  logic ex_hit1, ex_hit2, mem_ld_hit, load_use, branch_stall, stall, take;
  assign ex_hit1 = idex.ctrl.reg_wr && idex.rd != 5'd0 && use_rs1 && idex.rd == rs1;
  assign ex_hit2 = idex.ctrl.reg_wr && idex.rd != 5'd0 && use_rs2 && idex.rd == rs2;
  assign mem_ld_hit = exmem.mem_rd && exmem.rd != 5'd0 &&
                      ((use_rs1 && exmem.rd == rs1) || (use_rs2 && exmem.rd == rs2));
  assign load_use     = idex.ctrl.mem_rd && (ex_hit1 || ex_hit2);
  assign branch_stall = is_branch && (ex_hit1 || ex_hit2 || mem_ld_hit);
  assign stall        = load_use || branch_stall;
  assign take = is_branch && !stall &&
                ((funct3 == 3'b000 && br_a == br_b) || (funct3 == 3'b001 && br_a != br_b));

  always_comb begin
    idex_next        = '0;
    idex_next.ctrl   = ctrl_id;
    idex_next.rs1    = rs1;
    idex_next.rs2    = rs2;
    idex_next.rd     = rd;
    idex_next.funct3 = funct3;
    idex_next.f7b5   = ifid_instr[30];
    idex_next.rd1    = rf_rd1;
    idex_next.rd2    = rf_rd2;
    idex_next.imm    = imm_id;
  end

  // ---------------- EX ----------------
  logic [1:0]  forward_a, forward_b;
  logic [31:0] op_a, op_b_fwd, alu_b, alu_res;
  logic [4:0]  shamt;
  alu_op_e     alu_op;

  always_comb begin
    forward_a = FWD_RF;
    forward_b = FWD_RF;
    if (exmem.reg_wr && exmem.rd != 5'd0 && exmem.rd == idex.rs1)      forward_a = FWD_EXMEM;
    else if (memwb.reg_wr && memwb.rd != 5'd0 && memwb.rd == idex.rs1) forward_a = FWD_MEMWB;
    if (exmem.reg_wr && exmem.rd != 5'd0 && exmem.rd == idex.rs2)      forward_b = FWD_EXMEM;
    else if (memwb.reg_wr && memwb.rd != 5'd0 && memwb.rd == idex.rs2) forward_b = FWD_MEMWB;
  end

  always_comb begin
    case (forward_a)
      FWD_EXMEM: op_a = exmem.alu;
      FWD_MEMWB: op_a = wb_data;
      default:   op_a = idex.rd1;
    endcase
    case (forward_b)
      FWD_EXMEM: op_b_fwd = exmem.alu;
      FWD_MEMWB: op_b_fwd = wb_data;
      default:   op_b_fwd = idex.rd2;
    endcase
  end

  assign alu_b = idex.ctrl.mux_ula ? idex.imm : op_b_fwd;
  assign shamt = alu_b[4:0];

  // funct7[5] means SUB only for register-register ops; for immediates it is an imm bit.
  always_comb begin
    alu_op = ALU_ADD;
    case (idex.ctrl.ula_op)
      ULA_SUB: alu_op = ALU_SUB;
      ULA_FUNCT: begin
        case (idex.funct3)
          3'b000:  alu_op = (!idex.ctrl.mux_ula && idex.f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = idex.f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_res = op_a - alu_b;
      ALU_AND:  alu_res = op_a & alu_b;
      ALU_OR:   alu_res = op_a | alu_b;
      ALU_XOR:  alu_res = op_a ^ alu_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'd0, op_a < alu_b};
      default:  alu_res = op_a + alu_b;
    endcase
  end

  always_comb begin
    exmem_next         = '0;
    exmem_next.reg_wr  = idex.ctrl.reg_wr;
    exmem_next.mem_rd  = idex.ctrl.mem_rd;
    exmem_next.mem_wr  = idex.ctrl.mem_wr;
    exmem_next.mux_reg = idex.ctrl.mux_reg;
    exmem_next.rd      = idex.rd;
    exmem_next.alu     = alu_res;
    exmem_next.wdata   = op_b_fwd;
  end

  // ---------------- MEM / WB ----------------
  logic [7:0]  mem_idx;
  logic [31:0] mem_wdata, mem_rdata;
  logic        dmem_we;

  assign mem_idx   = exmem.alu[9:2];
  assign mem_wdata = exmem.wdata;
  assign mem_rdata = dmem[mem_idx];
  assign dmem_we   = exmem.mem_wr && enable && rst;

  always_ff @(posedge clk) begin
    if (dmem_we) dmem[mem_idx] <= mem_wdata;
  end

  always_comb begin
    memwb_next         = '0;
    memwb_next.reg_wr  = exmem.reg_wr;
    memwb_next.mux_reg = exmem.mux_reg;
    memwb_next.rd      = exmem.rd;
    memwb_next.alu     = exmem.alu;
    memwb_next.mdata   = mem_rdata;
  end

  assign wb_rd   = memwb.rd;
  assign wb_data = memwb.mux_reg ? memwb.mdata : memwb.alu;
  assign rf_we   = memwb.reg_wr && memwb.rd != 5'd0 && enable && rst;

  // ---------------- pipeline state ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc         <= '0;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      idex       <= '0;
      exmem      <= '0;
      memwb      <= '0;
    end else if (enable) begin
      if (!stall) begin
        pc         <= take ? ifid_pc + imm_id : pc + 32'd4;
        ifid_pc    <= pc;
        ifid_instr <= take ? NOP_INSTR : out_instruction;
      end
      idex  <= stall ? '0 : idex_next;
      exmem <= exmem_next;
      memwb <= memwb_next;
    end
  end

endmodule

// File: tb/tb_rv32i_pipeline.sv
// Directed programs with a writeback/store scoreboard popped by a negedge monitor.
module tb_rv32i_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] pc_out, out_instruction;

  rv32i_pipeline dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pc_out(pc_out), .out_instruction(out_instruction)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [36:0] exp_wb [$];
  logic [39:0] exp_st [$];
  logic [36:0] mon_wb;
  logic [39:0] mon_st;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every architectural register write and store must match the queue head.
  always @(negedge clk) begin
    if (dut.rf_we) begin
      if (exp_wb.size() == 0) begin
        checks++; failures++;
        $display("FAIL wb_unexpected: got x%0d=%h expected no write", dut.wb_rd, dut.wb_data);
      end else begin
        mon_wb = exp_wb.pop_front();
        check("wb", {27'd0, dut.wb_rd, dut.wb_data}, {27'd0, mon_wb});
      end
    end
    if (dut.dmem_we) begin
      if (exp_st.size() == 0) begin
        checks++; failures++;
        $display("FAIL st_unexpected: got dmem[%0d]=%h expected no store", dut.mem_idx, dut.mem_wdata);
      end else begin
        mon_st = exp_st.pop_front();
        check("store", {24'd0, dut.mem_idx, dut.mem_wdata}, {24'd0, mon_st});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic begin_test();
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0000_0013;
  endtask

  task automatic release_rst();
    tick(1);
    rst = 1'b1;
  endtask

  task automatic end_test(input string name);
    tick(12);
    check({name, "_wb_drained"}, 64'(exp_wb.size()), 64'd0);
    check({name, "_st_drained"}, 64'(exp_st.size()), 64'd0);
  endtask

  task automatic push_wb(input logic [4:0] r, input logic [31:0] v);
    exp_wb.push_back({r, v});
  endtask

  initial begin
    // basic add, x0 write discarded, x0 reads zero
    begin_test();
    dut.imem[0] = 32'h002081B3;   // add x3,x1,x2
    dut.imem[1] = 32'h00500013;   // addi x0,x0,5
    dut.imem[2] = 32'h000007B3;   // add x15,x0,x0
    dut.u_rf.regs[1] <= 32'd10; dut.u_rf.regs[2] <= 32'd20;
    dut.u_rf.regs[3] <= 32'd0;  dut.u_rf.regs[15] <= 32'd99;
    push_wb(5'd3, 32'd30); push_wb(5'd15, 32'd0);
    release_rst();
    check("reset_pc", 64'(pc_out), 64'd0);
    check("fetch_word", 64'(out_instruction), 64'h002081B3);
    tick(1); check("pc_4", 64'(pc_out), 64'd4);
    tick(1); check("pc_8", 64'(pc_out), 64'd8);
    tick(1); check("pc_12", 64'(pc_out), 64'd12);
    tick(1); check("x3_not_yet", 64'(dut.u_rf.regs[3]), 64'd0);
    tick(1); check("x3_at_5", 64'(dut.u_rf.regs[3]), 64'd30);
    end_test("basic");
    check("x15_zero", 64'(dut.u_rf.regs[15]), 64'd0);

    // EX/MEM forwarding, no stall
    begin_test();
    dut.imem[0] = 32'h002081B3;   // add x3,x1,x2
    dut.imem[1] = 32'h40118233;   // sub x4,x3,x1
    dut.u_rf.regs[3] <= 32'd0; dut.u_rf.regs[4] <= 32'd0;
    push_wb(5'd3, 32'd30); push_wb(5'd4, 32'd20);
    release_rst();
    tick(3);
    check("fwdA_exmem", 64'(dut.forward_a), 64'd2);
    check("fwdB_rf", 64'(dut.forward_b), 64'd0);
    check("fwd_no_stall_pc", 64'(pc_out), 64'd12);
    end_test("fwd");
    check("x4", 64'(dut.u_rf.regs[4]), 64'd20);

    // load-use stall
    begin_test();
    dut.imem[0] = 32'h04002283;   // lw x5,64(x0)
    dut.imem[1] = 32'h00528333;   // add x6,x5,x5
    dut.dmem[16] <= 32'd3;
    dut.u_rf.regs[5] <= 32'd0; dut.u_rf.regs[6] <= 32'd0;
    push_wb(5'd5, 32'd3); push_wb(5'd6, 32'd6);
    release_rst();
    tick(2); check("lu_pc_8", 64'(pc_out), 64'd8);
    tick(1); check("lu_pc_held", 64'(pc_out), 64'd8);
    tick(1); check("lu_pc_12", 64'(pc_out), 64'd12);
    check("lu_fwdA_memwb", 64'(dut.forward_a), 64'd1);
    check("lu_fwdB_memwb", 64'(dut.forward_b), 64'd1);
    end_test("loaduse");
    check("x6", 64'(dut.u_rf.regs[6]), 64'd6);

    // store then load
    begin_test();
    dut.imem[0] = 32'h00202423;   // sw x2,8(x0)
    dut.imem[1] = 32'h00802383;   // lw x7,8(x0)
    dut.dmem[2] <= 32'd0; dut.u_rf.regs[7] <= 32'd0;
    exp_st.push_back({8'd2, 32'd20});
    push_wb(5'd7, 32'd20);
    release_rst();
    end_test("swlw");
    check("dmem2", 64'(dut.dmem[2]), 64'd20);

    // taken beq flushes fall-through
    begin_test();
    dut.imem[0] = 32'h00108463;   // beq x1,x1,+8
    dut.imem[1] = 32'h00100413;   // addi x8,x0,1
    dut.imem[2] = 32'h00200493;   // addi x9,x0,2
    dut.u_rf.regs[8] <= 32'd0; dut.u_rf.regs[9] <= 32'd0;
    push_wb(5'd9, 32'd2);
    release_rst();
    tick(1); check("beq_pc_4", 64'(pc_out), 64'd4);
    tick(1); check("beq_pc_8", 64'(pc_out), 64'd8);
    tick(1); check("beq_pc_12", 64'(pc_out), 64'd12);
    end_test("beq");
    check("beq_x8_flushed", 64'(dut.u_rf.regs[8]), 64'd0);

    // not-taken bne
    begin_test();
    dut.imem[0] = 32'h00109463;   // bne x1,x1,+8
    dut.imem[1] = 32'h00100413;
    dut.imem[2] = 32'h00200493;
    dut.u_rf.regs[8] <= 32'd0; dut.u_rf.regs[9] <= 32'd0;
    push_wb(5'd8, 32'd1); push_wb(5'd9, 32'd2);
    release_rst();
    tick(2); check("bne_pc_8", 64'(pc_out), 64'd8);
    end_test("bne");
    check("bne_x8", 64'(dut.u_rf.regs[8]), 64'd1);

    // enable freeze mid-program
    begin_test();
    dut.imem[0] = 32'h00500513;   // addi x10,x0,5
    dut.imem[1] = 32'h00150593;   // addi x11,x10,1
    dut.imem[2] = 32'h00158613;   // addi x12,x11,1
    dut.u_rf.regs[10] <= 32'd0; dut.u_rf.regs[11] <= 32'd0; dut.u_rf.regs[12] <= 32'd0;
    push_wb(5'd10, 32'd5); push_wb(5'd11, 32'd6); push_wb(5'd12, 32'd7);
    release_rst();
    tick(4);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("frz_pc", 64'(pc_out), 64'd16);
    end
    check("frz_x10", 64'(dut.u_rf.regs[10]), 64'd0);
    enable = 1'b1;
    tick(1);
    check("resume_pc", 64'(pc_out), 64'd20);
    check("resume_x10", 64'(dut.u_rf.regs[10]), 64'd5);
    end_test("enable");
    check("x12", 64'(dut.u_rf.regs[12]), 64'd7);

    // reset mid-program discards in-flight writes
    begin_test();
    dut.imem[0] = 32'h00700693;   // addi x13,x0,7
    dut.imem[1] = 32'h00900713;   // addi x14,x0,9
    dut.u_rf.regs[13] <= 32'd0; dut.u_rf.regs[14] <= 32'd0;
    push_wb(5'd13, 32'd7); push_wb(5'd14, 32'd9);
    release_rst();
    tick(4);
    rst = 1'b0;
    tick(1);
    check("midrst_pc", 64'(pc_out), 64'd0);
    check("midrst_x13", 64'(dut.u_rf.regs[13]), 64'd0);
    rst = 1'b1;
    end_test("midrst");
    check("x14", 64'(dut.u_rf.regs[14]), 64'd9);

    // ALU op mix
    begin_test();
    dut.imem[0] = 32'h401858B3;   // sra  x17,x16,x1
    dut.imem[1] = 32'h00182933;   // slt  x18,x16,x1
    dut.imem[2] = 32'h0100B9B3;   // sltu x19,x1,x16
    dut.imem[3] = 32'h0020CA33;   // xor  x20,x1,x2
    dut.imem[4] = 32'h01C85A93;   // srli x21,x16,28
    dut.u_rf.regs[16] <= 32'hFFFF_FFF0;
    push_wb(5'd17, 32'hFFFF_FFFF); push_wb(5'd18, 32'd1); push_wb(5'd19, 32'd1);
    push_wb(5'd20, 32'd30); push_wb(5'd21, 32'h0000_000F);
    release_rst();
    end_test("alu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
